// File: rtl/imem_port_arbiter_pkg.sv
// imem_port_arbiter_pkg: shared widths and read-owner encoding for the inst RAM arbiter
package imem_port_arbiter_pkg;
  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam int ADDR_W = PC_W;
  localparam int DATA_W = INST_W;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;
endpackage

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, host and RAM signal bundle around the inst RAM arbiter
interface imem_port_arbiter_if
  import imem_port_arbiter_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);
  logic core_halt;
  logic fetch_req;
  logic [AW-1:0] fetch_addr;
  logic fetch_stall;
  logic [DW-1:0] fetch_data;
  logic fetch_valid;
  logic host_req;
  logic host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic host_ready;
  logic [DW-1:0] host_rdata;
  logic host_rvalid;
  logic mem_en;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic grant_host;
  modport master (
    input core_halt, fetch_req, fetch_addr, host_req, host_we, host_addr, host_wdata, mem_rdata,
    output fetch_stall, fetch_data, fetch_valid, host_ready, host_rdata, host_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata, grant_host
  );
  modport slave (
    output core_halt, fetch_req, fetch_addr, host_req, host_we, host_addr, host_wdata, mem_rdata,
    input fetch_stall, fetch_data, fetch_valid, host_ready, host_rdata, host_rvalid,
    input mem_en, mem_we, mem_addr, mem_wdata, grant_host
  );
endinterface

// File: rtl/imem_arb_wait_cnt.sv
// imem_arb_wait_cnt: saturating count of consecutive cycles the host lost arbitration
module imem_arb_wait_cnt #(
  parameter int MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] cnt_o,
  output logic       sat_o
);
  logic [3:0] cnt_q, cnt_d;
  assign sat_o = cnt_q == 4'(MAX);
  assign cnt_o = cnt_q;
  always_comb cnt_d = clr_i ? 4'd0 : (inc_i && !sat_o) ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 4'd0 : cnt_d;
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port inst RAM between fetch and the host loader,
// force-granting the host after HOST_MAX_WAIT consecutive losses
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int HOST_MAX_WAIT = 4
) (
  input logic clk,
  input logic rst,
  imem_port_arbiter_if.master bus
);
  logic host_win, fetch_win, sat, inc;
  logic [3:0] wait_cnt;
  logic [1:0] rd_owner_q, rd_owner_d;
  imem_arb_wait_cnt #(.MAX(HOST_MAX_WAIT)) u_wait (
    .clk(clk), .rst(rst), .inc_i(inc), .clr_i(!inc), .cnt_o(wait_cnt), .sat_o(sat)
  );
  // Grants are suppressed during reset; halt hands the RAM to the host unconditionally.
  always_comb begin
    host_win = !rst && bus.host_req && (bus.core_halt || !bus.fetch_req || sat);
    fetch_win = !rst && !bus.core_halt && bus.fetch_req && !host_win;
    inc = bus.host_req && !host_win;
    rd_owner_d = fetch_win ? OWN_FETCH : (host_win && !bus.host_we) ? OWN_HOST : OWN_NONE;
  end
  always_ff @(posedge clk) rd_owner_q <= rst ? OWN_NONE : rd_owner_d;
  assign bus.grant_host = host_win;
  assign bus.host_ready = host_win;
  assign bus.fetch_stall = bus.fetch_req && !fetch_win;
  assign bus.mem_en = host_win || fetch_win;
  assign bus.mem_we = host_win && bus.host_we;
  assign bus.mem_addr = fetch_win ? bus.fetch_addr : host_win ? bus.host_addr : '0;
  assign bus.mem_wdata = host_win ? bus.host_wdata : '0;
  // Responses in flight when reset arrives are dropped in the reset cycle itself.
  assign bus.fetch_valid = !rst && rd_owner_q == OWN_FETCH;
  assign bus.host_rvalid = !rst && rd_owner_q == OWN_HOST;
  assign bus.fetch_data = bus.mem_rdata;
  assign bus.host_rdata = bus.mem_rdata;
  logic unused;
  assign unused = ^wait_cnt;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed checks of the inst RAM arbiter against a small behavioural RAM
module tb_imem_port_arbiter;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int failures = 0;
  imem_port_arbiter_if bus ();
  imem_port_arbiter #(.HOST_MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // RAM: unwritten words read back as 0x1000_0000 + address
  logic [31:0] ram [256];
  logic [255:0] wr;
  always @(posedge clk) begin
    if (rst) wr <= '0;
    else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      wr[bus.mem_addr[7:0]] <= 1'b1;
    end
    if (bus.mem_en)
      bus.mem_rdata <= wr[bus.mem_addr[7:0]] ? ram[bus.mem_addr[7:0]] : 32'h1000_0000 + bus.mem_addr;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    bus.core_halt = 0; bus.fetch_req = 1; bus.fetch_addr = 0;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    cyc(); cyc();
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_host_ready", 32'(bus.host_ready), 0);
    chk("rst_fetch_stall", 32'(bus.fetch_stall), 1);
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 0);
    chk("rst_host_rvalid", 32'(bus.host_rvalid), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst = 0; bus.host_req = 0; bus.fetch_req = 0;
    cyc();
    for (int n = 0; n < 10; n++) begin
      bus.fetch_req = 1; bus.fetch_addr = 32'(n);
      #1;
      chk("stream_mem_en", 32'(bus.mem_en), 1);
      chk("stream_stall", 32'(bus.fetch_stall), 0);
      chk("stream_addr", bus.mem_addr, 32'(n));
      if (n > 0) begin
        chk("stream_valid", 32'(bus.fetch_valid), 1);
        chk("stream_data", bus.fetch_data, 32'h1000_0000 + 32'(n - 1));
      end
      cyc();
    end
    bus.fetch_req = 0;
    #1;
    chk("stream_last_valid", 32'(bus.fetch_valid), 1);
    chk("stream_last_data", bus.fetch_data, 32'h1000_0009);
    chk("idle_mem_en", 32'(bus.mem_en), 0);
    chk("idle_stall", 32'(bus.fetch_stall), 0);
    chk("idle_mem_addr", bus.mem_addr, 0);
    cyc();
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 32'h10; bus.host_wdata = 32'hDEADBEEF;
    #1;
    chk("hw_ready", 32'(bus.host_ready), 1);
    chk("hw_mem_we", 32'(bus.mem_we), 1);
    chk("hw_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("hw_grant_host", 32'(bus.grant_host), 1);
    cyc();
    bus.host_we = 0; bus.host_wdata = 0;
    #1;
    chk("hr_ready", 32'(bus.host_ready), 1);
    chk("hr_mem_we", 32'(bus.mem_we), 0);
    chk("hw_no_rvalid", 32'(bus.host_rvalid), 0);
    cyc();
    bus.host_req = 0;
    #1;
    chk("hr_rvalid", 32'(bus.host_rvalid), 1);
    chk("hr_rdata", bus.host_rdata, 32'hDEADBEEF);
    chk("hr_no_fvalid", 32'(bus.fetch_valid), 0);
    cyc();
    bus.fetch_req = 1; bus.fetch_addr = 32'h20; bus.host_req = 1; bus.host_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("starve_ready", 32'(bus.host_ready), 32'(i == 4));
      chk("starve_stall", 32'(bus.fetch_stall), 32'(i == 4));
      cyc();
    end
    bus.host_req = 0;
    #1;
    chk("starve_fetch_back", 32'(bus.fetch_stall), 0);
    chk("starve_rvalid", 32'(bus.host_rvalid), 1);
    chk("starve_rdata", bus.host_rdata, 32'hDEADBEEF);
    cyc();
    bus.core_halt = 1; bus.host_req = 1; bus.host_we = 1;
    for (int i = 0; i < 8; i++) begin
      bus.host_addr = 32'h40 + 32'(i); bus.host_wdata = 32'hA5A5_0000 + 32'(i);
      #1;
      chk("halt_w_ready", 32'(bus.host_ready), 1);
      chk("halt_w_stall", 32'(bus.fetch_stall), 1);
      cyc();
    end
    bus.host_we = 0;
    for (int i = 0; i < 8; i++) begin
      bus.host_addr = 32'h40 + 32'(i);
      #1;
      chk("halt_r_ready", 32'(bus.host_ready), 1);
      chk("halt_r_stall", 32'(bus.fetch_stall), 1);
      if (i > 0) begin
        chk("halt_r_rvalid", 32'(bus.host_rvalid), 1);
        chk("halt_r_rdata", bus.host_rdata, 32'hA5A5_0000 + 32'(i - 1));
      end
      cyc();
    end
    bus.host_req = 0;
    #1;
    chk("halt_r_last", bus.host_rdata, 32'hA5A5_0007);
    chk("halt_no_fvalid", 32'(bus.fetch_valid), 0);
    chk("halt_idle_stall", 32'(bus.fetch_stall), 1);
    cyc();
    bus.core_halt = 0; bus.host_req = 1; bus.host_addr = 32'h10;
    #1;
    chk("unhalt_stall", 32'(bus.fetch_stall), 0);
    chk("unhalt_ready", 32'(bus.host_ready), 0);
    cyc();
    bus.core_halt = 1;
    #1;
    chk("halt_rise_stall", 32'(bus.fetch_stall), 1);
    chk("halt_rise_ready", 32'(bus.host_ready), 1);
    chk("halt_rise_fvalid", 32'(bus.fetch_valid), 1);
    cyc();
    bus.core_halt = 0; bus.host_req = 0; bus.fetch_req = 0;
    cyc();
    bus.fetch_req = 1; bus.fetch_addr = 32'd3; bus.host_req = 1;
    #1;
    chk("pre_rst_stall", 32'(bus.fetch_stall), 0);
    cyc();
    #1;
    chk("pre_rst_grant", 32'(bus.mem_en && !bus.grant_host), 1);
    cyc();
    rst = 1;
    #1;
    chk("mid_rst_fvalid", 32'(bus.fetch_valid), 0);
    chk("mid_rst_mem_en", 32'(bus.mem_en), 0);
    chk("mid_rst_stall", 32'(bus.fetch_stall), 1);
    cyc();
    rst = 0; bus.fetch_req = 0; bus.host_req = 0;
    #1;
    chk("post_rst_fvalid", 32'(bus.fetch_valid), 0);
    chk("post_rst_wait_cnt", 32'(dut.u_wait.cnt_q), 0);
    cyc();
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 32'h10;
    #1;
    chk("ord_hr_ready", 32'(bus.host_ready), 1);
    chk("ord_n_rvalid", 32'(bus.host_rvalid), 0);
    chk("ord_n_fvalid", 32'(bus.fetch_valid), 0);
    cyc();
    bus.host_req = 0; bus.fetch_req = 1; bus.fetch_addr = 32'd5;
    #1;
    chk("ord_n1_rvalid", 32'(bus.host_rvalid), 1);
    chk("ord_n1_fvalid", 32'(bus.fetch_valid), 0);
    cyc();
    bus.fetch_req = 0;
    #1;
    chk("ord_n2_rvalid", 32'(bus.host_rvalid), 0);
    chk("ord_n2_fvalid", 32'(bus.fetch_valid), 1);
    chk("ord_n2_fdata", bus.fetch_data, 32'h1000_0005);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction RAM between the fetch stage (read-only, nearly every cycle) and a host/debug loader port (program load and read-back).
- Sits between fetch and the inst RAM instance.
- Drives the stall that gates the fetch pc_en.
- Returns read data to whichever requester issued the read.
- Guarantees the host a slot within a bounded number of cycles while the core runs.

Parameters:
- ADDR_W, 32, word address width (equals PC width)
- DATA_W, 32, instruction word width
- HOST_MAX_WAIT, 4, consecutive cycles the host may lose arbitration before it is force-granted (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- core_halt  in  1  host holds core; host always owns RAM
- fetch_req  in  1  fetch wants a read this cycle
- fetch_addr  in  ADDR_W  fetch word address (PC)
- fetch_stall  out  1  fetch not granted this cycle; fetch gates pc_en with it
- fetch_data  out  DATA_W  instruction read data
- fetch_valid  out  1  fetch_data valid (one cycle after fetch grant)
- host_req  in  1  host transaction request
- host_we  in  1  1=write, 0=read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_ready  out  1  host transaction accepted this cycle
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  host_rdata valid (one cycle after read accept)
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency
- grant_host  out  1  debug: host owns RAM this cycle

Behaviour:
- Grant decision is combinational each cycle; wait_cnt and rd_owner are registers.
- Priority, first match wins:
  - core_halt=1: grant host if host_req. Fetch never granted; fetch_stall=1.
  - host_req && fetch_req && wait_cnt==HOST_MAX_WAIT: grant host; fetch_stall=1.
  - host_req && fetch_req: grant fetch; host_ready=0.
  - host_req only: grant host.
  - fetch_req only: grant fetch.
  - Neither: no grant; mem_en=0.
- fetch_stall = fetch_req && !grant_fetch. It is 0 whenever fetch_req=0.
- host_ready = grant_host. The transaction completes in the cycle host_req && host_ready. The host holds its request fields stable until then.
- Mem outputs:
  - Grant fetch: mem_en=1, mem_we=0, mem_addr=fetch_addr.
  - Grant host: mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - No grant: mem_en=0, mem_we=0. mem_addr and mem_wdata are don't-care but must be driven to 0.
- wait_cnt (4-bit):
  - Increments, saturating at HOST_MAX_WAIT, on each cycle host_req=1 and host not granted.
  - Clears to 0 on a host grant or when host_req=0.
- rd_owner register, encoded NONE/FETCH/HOST, loaded every cycle:
  - FETCH on fetch grant.
  - HOST on host read grant.
  - NONE on host write grant or no grant.
- Read return, next cycle:
  - fetch_valid = (rd_owner==FETCH) and host_rvalid = (rd_owner==HOST), both registered.
  - fetch_data = host_rdata = mem_rdata. Consumers qualify with their valid.
- Latency: fetch read 1 cycle; host read 1 cycle after accept; host write has no response.
- Boundary conditions:
  - HOST_MAX_WAIT reached while the core is running costs fetch exactly one stall cycle, then wait_cnt=0 and fetch wins again.
  - core_halt rising mid-cycle takes effect the same cycle. A fetch read granted the prior cycle still returns fetch_valid.
  - core_halt falling with both requesting: fetch wins (wait_cnt restarts from 0).
  - Address wrap is the RAM's concern; the arbiter passes addresses unmodified.
- Reset: wait_cnt=0, rd_owner=NONE, fetch_valid=0, host_rvalid=0. Any in-flight read response is dropped; no valid follows the reset cycle. Combinational outputs follow the inputs during reset, and grants are suppressed (mem_en=0, host_ready=0, fetch_stall=fetch_req).

Decomposition:
- Shared defines package: ADDR_W/DATA_W tied to the existing PC/instruction width defines; rd_owner encoding constants OWN_NONE=2'd0, OWN_FETCH=2'd1, OWN_HOST=2'd2.
- One natural sub-module: imem_arb_wait_cnt, the saturating starvation counter with inc/clr/sat outputs.

Test Plan:
- fetch_req=1 for 10 cycles, host idle, addrs 0..9 -> mem_en=1 every cycle, fetch_stall=0, fetch_valid=1 from cycle 1, fetch_data = RAM[n-1].
- Host write addr 0x10 data 0xDEADBEEF with fetch idle -> host_ready=1 same cycle, mem_we=1. Host read 0x10 -> host_rvalid next cycle, host_rdata=0xDEADBEEF.
- fetch_req and host_req both held high, HOST_MAX_WAIT=4 -> host_ready=0 for cycles 0..3, host_ready=1 and fetch_stall=1 in cycle 4, fetch granted in cycle 5.
- core_halt=1, 8 back-to-back host writes then reads -> fetch_stall=1 throughout, all host ops accepted with zero wait, read data matches.
- Fetch granted in cycle N, rst=1 in cycle N+1 -> fetch_valid=0 in N+1 and N+2, wait_cnt=0 after reset.
- Host read granted in cycle N with fetch granted in N+1 -> host_rvalid only in N+1, fetch_valid only in N+2, no overlap.
